// File: rtl/aes_key_loader.sv
// Byte-serial AES key ingest: shifts key bytes MSB-first into a register and holds
// the assembled key until acknowledged. Optional macro AES_KEY_ZEROIZE_EN clears key on handoff.
module aes_key_loader #(
  parameter int KEY_BYTES = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   in_valid,
  input  logic [7:0]             in_data,
  output logic                   in_ready,
  output logic [8*KEY_BYTES-1:0] key,
  output logic                   key_valid,
  input  logic                   key_ack,
  output logic [5:0]             byte_cnt,
  output logic [1:0]             dbg_state
);

  localparam int KW = 8 * KEY_BYTES;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [KW-1:0] key_q, key_d;
  logic [5:0]    cnt_q, cnt_d;

  // Handshake: a byte is taken when in_valid && in_ready at a rising edge;
  // in_ready is a pure decode of the state register, so no input reaches an output.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      key_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          key_d   = '0;
          cnt_d   = '0;
        end
      end
      LOAD: begin
        // A restart discards any byte offered in the same cycle.
        if (start) begin
          key_d = '0;
          cnt_d = '0;
        end else if (in_valid) begin
          key_d = {key_q[KW-9:0], in_data};
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == 6'(KEY_BYTES - 1)) state_d = HOLD;
        end
      end
      HOLD: begin
        if (start) begin
          state_d = LOAD;
          key_d   = '0;
          cnt_d   = '0;
        end else if (key_ack) begin
          state_d = IDLE;
`ifdef AES_KEY_ZEROIZE_EN
          key_d   = '0;
          cnt_d   = '0;
`else
          key_d   = key_q;
          cnt_d   = cnt_q;
`endif
        end
      end
      default: begin
        state_d = IDLE;
        key_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  assign in_ready  = (state_q == LOAD);
  assign key_valid = (state_q == HOLD);
  assign key       = key_q;
  assign byte_cnt  = cnt_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_aes_key_loader.sv
// Directed bench for aes_key_loader: a 32-byte instance for most scenarios and a
// 16-byte instance for the AES-128 key length.
module tb_aes_key_loader;

  localparam logic [255:0] FIPS256 =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] FIPS128 = 128'h000102030405060708090a0b0c0d0e0f;

  logic         clk = 1'b0;
  logic         rst_n, start, start16, in_valid, key_ack;
  logic [7:0]   in_data;
  logic         in_ready, key_valid, in_ready16, key_valid16;
  logic [255:0] key;
  logic [127:0] key16;
  logic [5:0]   byte_cnt, byte_cnt16;
  logic [1:0]   dbg_state, dbg_state16;
  logic [255:0] exp_idle_key;
  logic [5:0]   exp_idle_cnt;

  int checks = 0;
  int errors = 0;

  // Clock / reset
  always #5 clk = ~clk;

  aes_key_loader #(.KEY_BYTES(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .key(key), .key_valid(key_valid), .key_ack(key_ack),
    .byte_cnt(byte_cnt), .dbg_state(dbg_state)
  );

  aes_key_loader #(.KEY_BYTES(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready16), .key(key16), .key_valid(key_valid16), .key_ack(key_ack),
    .byte_cnt(byte_cnt16), .dbg_state(dbg_state16)
  );

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input int n, input logic [7:0] first, input bit gapped);
    for (int i = 0; i < n; i++) begin
      if (gapped && ($urandom_range(0, 1) == 1)) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom_range(0, 255));
        tick();
      end
      in_valid = 1'b1;
      in_data  = first + 8'(i);
      tick();
    end
    in_valid = 1'b0;
  endtask

  // Scoreboard check
  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; start16 = 1'b0; key_ack = 1'b0;
    in_valid = 1'b1; in_data = 8'h55;
    tick(); tick();
    chk("rst_in_ready", 256'(in_ready), 256'd0);
    chk("rst_key_valid", 256'(key_valid), 256'd0);
    chk("rst_key", key, 256'd0);
    chk("rst_byte_cnt", 256'(byte_cnt), 256'd0);
    chk("rst_in_ready16", 256'(in_ready16), 256'd0);
    rst_n = 1'b1; in_valid = 1'b0;
    tick();

    // Back-to-back FIPS-197 key
    pulse_start();
    chk("start_in_ready", 256'(in_ready), 256'd1);
    chk("start_byte_cnt", 256'(byte_cnt), 256'd0);
    send(31, 8'h00, 1'b0);
    chk("b2b_kv_before_last", 256'(key_valid), 256'd0);
    chk("b2b_cnt_31", 256'(byte_cnt), 256'd31);
    send(1, 8'h1f, 1'b0);
    chk("b2b_key_valid", 256'(key_valid), 256'd1);
    chk("b2b_in_ready_low", 256'(in_ready), 256'd0);
    chk("b2b_key", key, FIPS256);
    chk("b2b_byte_cnt", 256'(byte_cnt), 256'd32);

    // HOLD freezes against offered bytes
    in_valid = 1'b1; in_data = 8'hee;
    tick(); tick();
    in_valid = 1'b0;
    chk("hold_key", key, FIPS256);
    chk("hold_cnt", 256'(byte_cnt), 256'd32);

    // Acknowledge
    key_ack = 1'b1;
    tick();
    key_ack = 1'b0;
`ifdef AES_KEY_ZEROIZE_EN
    exp_idle_key = 256'd0;
    exp_idle_cnt = 6'd0;
`else
    exp_idle_key = FIPS256;
    exp_idle_cnt = 6'd32;
`endif
    chk("ack_key_valid", 256'(key_valid), 256'd0);
    chk("ack_in_ready", 256'(in_ready), 256'd0);
    chk("ack_key", key, exp_idle_key);
    chk("ack_cnt", 256'(byte_cnt), 256'(exp_idle_cnt));

    // Bytes in IDLE are ignored, then a gapped load
    in_valid = 1'b1; in_data = 8'haa;
    tick(); tick(); tick();
    in_valid = 1'b0;
    chk("idle_key", key, exp_idle_key);
    chk("idle_cnt", 256'(byte_cnt), 256'(exp_idle_cnt));
    pulse_start();
    send(31, 8'h00, 1'b1);
    chk("gap_kv_before_last", 256'(key_valid), 256'd0);
    send(1, 8'h1f, 1'b0);
    chk("gap_key_valid", 256'(key_valid), 256'd1);
    chk("gap_key", key, FIPS256);
    key_ack = 1'b1;
    tick();
    key_ack = 1'b0;

    // Restart mid-load; the byte offered with start is dropped
    pulse_start();
    send(10, 8'h40, 1'b0);
    chk("mid_cnt_10", 256'(byte_cnt), 256'd10);
    start = 1'b1; in_valid = 1'b1; in_data = 8'haa;
    tick();
    start = 1'b0; in_valid = 1'b0;
    chk("restart_cnt", 256'(byte_cnt), 256'd0);
    chk("restart_key", key, 256'd0);
    chk("restart_in_ready", 256'(in_ready), 256'd1);
    send(32, 8'h00, 1'b0);
    chk("reload_key", key, FIPS256);
    chk("reload_key_valid", 256'(key_valid), 256'd1);

    // start with key_ack in HOLD: start wins
    start = 1'b1; key_ack = 1'b1;
    tick();
    start = 1'b0; key_ack = 1'b0;
    chk("startack_in_ready", 256'(in_ready), 256'd1);
    chk("startack_key_valid", 256'(key_valid), 256'd0);
    chk("startack_key", key, 256'd0);
    chk("startack_cnt", 256'(byte_cnt), 256'd0);

    // Reset after 17 bytes
    send(17, 8'h00, 1'b0);
    chk("pre_rst_cnt", 256'(byte_cnt), 256'd17);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst_in_ready", 256'(in_ready), 256'd0);
    chk("midrst_key_valid", 256'(key_valid), 256'd0);
    chk("midrst_key", key, 256'd0);
    chk("midrst_cnt", 256'(byte_cnt), 256'd0);

    // 16-byte instance
    start16 = 1'b1;
    tick();
    start16 = 1'b0;
    chk("k16_in_ready", 256'(in_ready16), 256'd1);
    send(15, 8'h00, 1'b0);
    chk("k16_kv_before_last", 256'(key_valid16), 256'd0);
    send(1, 8'h0f, 1'b0);
    chk("k16_key_valid", 256'(key_valid16), 256'd1);
    chk("k16_in_ready_low", 256'(in_ready16), 256'd0);
    chk("k16_key", 256'(key16), 256'(FIPS128));
    chk("k16_cnt", 256'(byte_cnt16), 256'd16);
    chk("k16_other_idle", 256'(in_ready), 256'd0);

    // Final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
